axi4_lite_responder: RTL and testbench
======================================

AXI4_LITE_RESPONDER -- requirements
Module: axi4_lite_responder

Interface
REQ-001 SHALL have parameter DW, 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter AW, 32, address width in bits.
REQ-003 SHALL have parameter RESP, 2'b00, response code driven on BRESP and RRESP.
REQ-004 SHALL have parameter READ_DATA, 32'hDEAD_BEEF, fixed read-data pattern, zero-extended/truncated to DW.
REQ-005 SHALL have parameter ECHO_ADDR, 0, when 1 RDATA returns the accepted ARADDR instead of READ_DATA.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have ports S_AXI_AWADDR input AW, S_AXI_AWVALID input 1, S_AXI_AWREADY output 1, forming the write-address channel.
REQ-009 SHALL have ports S_AXI_WDATA input DW, S_AXI_WSTRB input DW/8, S_AXI_WVALID input 1, S_AXI_WREADY output 1, forming the write-data channel.
REQ-010 SHALL have ports S_AXI_BRESP output 2, S_AXI_BVALID output 1, S_AXI_BREADY input 1, forming the write-response channel.
REQ-011 SHALL have ports S_AXI_ARADDR input AW, S_AXI_ARVALID input 1, S_AXI_ARREADY output 1, forming the read-address channel.
REQ-012 SHALL have ports S_AXI_RDATA output DW, S_AXI_RRESP output 2, S_AXI_RVALID output 1, S_AXI_RREADY input 1, forming the read-data channel.
REQ-013 SHALL have port wr_count  output  32  completed write transactions.
REQ-014 SHALL have port rd_count  output  32  completed read transactions.

Function
REQ-015 SHALL be a terminating AXI4-Lite slave: accepts every transaction, discards write data, never stalls indefinitely.
REQ-016 Write FSM SHALL have states W_COLLECT and W_RESP, with flags aw_held and w_held.
REQ-017 In W_COLLECT: AWREADY = !aw_held, WREADY = !w_held; BVALID = 0.
REQ-018 AW and W handshakes SHALL be accepted independently, in either order or in the same cycle; each sets its held flag.
REQ-019 When both are held (including both accepted in the same cycle), the FSM SHALL enter W_RESP on the next edge; BVALID = 1 and BRESP = RESP in W_RESP.
REQ-020 Latency: AW+W accepted at edge N -> BVALID high in the cycle after edge N.
REQ-021 In W_RESP: AWREADY = WREADY = 0; BVALID held until BVALID&&BREADY; that edge clears both flags and returns to W_COLLECT.
REQ-022 Read FSM SHALL have states R_IDLE (ARREADY = 1, RVALID = 0) and R_DATA (ARREADY = 0, RVALID = 1).
REQ-023 An AR handshake in R_IDLE SHALL latch ARADDR and enter R_DATA; RVALID is high the cycle after acceptance.
REQ-024 RDATA SHALL equal READ_DATA, or the latched ARADDR when ECHO_ADDR = 1 (zero-extended if AW<DW, low DW bits if AW>DW); RRESP = RESP.
REQ-025 RVALID, RDATA and RRESP SHALL be stable until RREADY; the RVALID&&RREADY edge returns to R_IDLE.
REQ-026 Read and write paths SHALL be fully independent; concurrent activity on both SHALL not interact.
REQ-027 wr_count SHALL increment by 1 on each B handshake; rd_count by 1 on each R handshake; both may increment in the same cycle.
REQ-028 Counters SHALL saturate at 32'hFFFF_FFFF (no wrap).
REQ-029 Throughput SHALL be one write per 2 cycles minimum (collect, response) and one read per 2 cycles.
REQ-030 All READY/VALID outputs SHALL be 0 in any cycle in which reset is high.

Reset
REQ-031 On reset: W_COLLECT, aw_held = w_held = 0, R_IDLE, RDATA = 0, wr_count = rd_count = 0.
REQ-032 The first cycle after reset deasserts, AWREADY = WREADY = ARREADY = 1.
REQ-033 Reset mid-transaction SHALL drop any pending BVALID/RVALID and held AW/W without generating a response or a count.

Verification
REQ-034 AW and W valid same cycle, BREADY = 1 -> BVALID one cycle later, BRESP = RESP, wr_count 0 -> 1.
REQ-035 AW at cycle 0, W at cycle 5 -> AWREADY low cycles 1-5, BVALID at cycle 6, single count.
REQ-036 ECHO_ADDR = 1, ARADDR = 32'h0000_1234, RREADY held low 10 cycles -> RVALID and RDATA = 32'h1234 stable all 10 cycles, rd_count +1 only at the handshake.
REQ-037 Simultaneous B and R handshakes in one cycle -> wr_count and rd_count both increment that cycle.
REQ-038 Force counters to 32'hFFFF_FFFF, complete one write -> wr_count stays 32'hFFFF_FFFF.
REQ-039 Reset asserted while BVALID = 1 -> BVALID = 0 next cycle, wr_count = 0, AWREADY = 1 the first cycle after reset release.

Source files
------------

// File: rtl/axi4_lite_responder.sv
// Terminating AXI4-Lite slave: accepts every transaction, discards write data and returns a
// fixed response, with saturating counts of completed write and read transactions.
module axi4_lite_responder #(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 32,
  parameter logic [1:0]  RESP      = 2'b00,
  parameter logic [31:0] READ_DATA = 32'hDEAD_BEEF,
  parameter bit          ECHO_ADDR = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   S_AXI_AWADDR,
  input  logic            S_AXI_AWVALID,
  output logic            S_AXI_AWREADY,
  input  logic [DW-1:0]   S_AXI_WDATA,
  input  logic [DW/8-1:0] S_AXI_WSTRB,
  input  logic            S_AXI_WVALID,
  output logic            S_AXI_WREADY,
  output logic [1:0]      S_AXI_BRESP,
  output logic            S_AXI_BVALID,
  input  logic            S_AXI_BREADY,
  input  logic [AW-1:0]   S_AXI_ARADDR,
  input  logic            S_AXI_ARVALID,
  output logic            S_AXI_ARREADY,
  output logic [DW-1:0]   S_AXI_RDATA,
  output logic [1:0]      S_AXI_RRESP,
  output logic            S_AXI_RVALID,
  input  logic            S_AXI_RREADY,
  output logic [31:0]     wr_count,
  output logic [31:0]     rd_count
);

  localparam int unsigned PatW  = (DW > 32) ? DW : 32;
  localparam int unsigned AddrW = (DW > AW) ? DW : AW;

  typedef enum logic {WCollect, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  w_state_e        w_state_q, w_state_d;
  r_state_e        r_state_q, r_state_d;
  logic            aw_held_q, aw_held_d;
  logic            w_held_q, w_held_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [31:0]     wr_count_q, wr_count_d;
  logic [31:0]     rd_count_q, rd_count_d;
  logic [PatW-1:0] pat_ext;
  logic [AddrW-1:0] addr_ext;
  logic            unused_inputs;

  // Write address and data are accepted but never used.
  assign unused_inputs = ^{S_AXI_AWADDR, S_AXI_WDATA, S_AXI_WSTRB};

  assign pat_ext  = PatW'(READ_DATA);
  assign addr_ext = AddrW'(S_AXI_ARADDR);

  assign S_AXI_BRESP = RESP;
  assign S_AXI_RRESP = RESP;
  assign S_AXI_RDATA = rdata_q;
  assign wr_count    = wr_count_q;
  assign rd_count    = rd_count_q;

  // Write path: AW and W collected independently; response once both are held.
  always_comb begin
    w_state_d     = w_state_q;
    aw_held_d     = aw_held_q;
    w_held_d      = w_held_q;
    wr_count_d    = wr_count_q;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    case (w_state_q)
      WCollect: begin
        S_AXI_AWREADY = !reset && !aw_held_q;
        S_AXI_WREADY  = !reset && !w_held_q;
        aw_held_d     = aw_held_q | (S_AXI_AWREADY & S_AXI_AWVALID);
        w_held_d      = w_held_q | (S_AXI_WREADY & S_AXI_WVALID);
        if (aw_held_d && w_held_d) w_state_d = WResp;
      end
      WResp: begin
        S_AXI_BVALID = !reset;
        if (S_AXI_BVALID && S_AXI_BREADY) begin
          w_state_d = WCollect;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          if (wr_count_q != '1) wr_count_d = wr_count_q + 32'd1;
        end
      end
    endcase
  end

  // Read path: one outstanding read, data held until RREADY.
  always_comb begin
    r_state_d     = r_state_q;
    rdata_d       = rdata_q;
    rd_count_d    = rd_count_q;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (r_state_q)
      RIdle: begin
        S_AXI_ARREADY = !reset;
        if (S_AXI_ARREADY && S_AXI_ARVALID) begin
          r_state_d = RData;
          rdata_d   = ECHO_ADDR ? addr_ext[DW-1:0] : pat_ext[DW-1:0];
        end
      end
      RData: begin
        S_AXI_RVALID = !reset;
        if (S_AXI_RVALID && S_AXI_RREADY) begin
          r_state_d = RIdle;
          if (rd_count_q != '1) rd_count_d = rd_count_q + 32'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q  <= WCollect;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      r_state_q  <= RIdle;
      rdata_q    <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      r_state_q  <= r_state_d;
      rdata_q    <= rdata_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_responder.sv
// Scoreboard bench for axi4_lite_responder: expected responses are queued at issue time and
// compared by a monitor when each B/R handshake is about to happen.
module tb_axi4_lite_responder;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 32;
  localparam logic [1:0]  RESP = 2'b10;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [AW-1:0]   S_AXI_AWADDR = '0;
  logic            S_AXI_AWVALID = 1'b0;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA = '0;
  logic [DW/8-1:0] S_AXI_WSTRB = '0;
  logic            S_AXI_WVALID = 1'b0;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY = 1'b0;
  logic [AW-1:0]   S_AXI_ARADDR = '0;
  logic            S_AXI_ARVALID = 1'b0;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY = 1'b0;
  logic [31:0]     wr_count;
  logic [31:0]     rd_count;

  int checks = 0;
  int failures = 0;
  logic [1:0]    b_q[$];
  logic [DW-1:0] r_q[$];
  logic [31:0]   model_wr = '0;
  logic [31:0]   model_rd = '0;
  logic [1:0]    exp_b;
  logic [DW-1:0] exp_r;

  axi4_lite_responder #(
    .DW       (DW),
    .AW       (AW),
    .RESP     (RESP),
    .ECHO_ADDR(1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .S_AXI_AWADDR (S_AXI_AWADDR),
    .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA  (S_AXI_WDATA),
    .S_AXI_WSTRB  (S_AXI_WSTRB),
    .S_AXI_WVALID (S_AXI_WVALID),
    .S_AXI_WREADY (S_AXI_WREADY),
    .S_AXI_BRESP  (S_AXI_BRESP),
    .S_AXI_BVALID (S_AXI_BVALID),
    .S_AXI_BREADY (S_AXI_BREADY),
    .S_AXI_ARADDR (S_AXI_ARADDR),
    .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA  (S_AXI_RDATA),
    .S_AXI_RRESP  (S_AXI_RRESP),
    .S_AXI_RVALID (S_AXI_RVALID),
    .S_AXI_RREADY (S_AXI_RREADY),
    .wr_count     (wr_count),
    .rd_count     (rd_count)
  );

  always #5 clk = ~clk;

  // Monitor: at the falling edge a VALID&&READY pair means a handshake at the next rising edge.
  always @(negedge clk) begin
    if (!reset && S_AXI_BVALID && S_AXI_BREADY) begin
      checks++;
      if (b_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_b: got BRESP=%b with nothing expected", S_AXI_BRESP);
      end else begin
        exp_b = b_q.pop_front();
        if (S_AXI_BRESP !== exp_b) begin
          failures++;
          $display("FAIL b_resp: got %b expected %b", S_AXI_BRESP, exp_b);
        end
      end
      checks++;
      if (wr_count !== model_wr) begin
        failures++;
        $display("FAIL wr_count_pre_b: got %h expected %h", wr_count, model_wr);
      end
      if (model_wr != 32'hFFFF_FFFF) model_wr = model_wr + 32'd1;
    end
    if (!reset && S_AXI_RVALID && S_AXI_RREADY) begin
      checks++;
      if (r_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_r: got RDATA=%h with nothing expected", S_AXI_RDATA);
      end else begin
        exp_r = r_q.pop_front();
        if (S_AXI_RDATA !== exp_r || S_AXI_RRESP !== RESP) begin
          failures++;
          $display("FAIL r_data: got %h/%b expected %h/%b", S_AXI_RDATA, S_AXI_RRESP, exp_r,
                   RESP);
        end
      end
      checks++;
      if (rd_count !== model_rd) begin
        failures++;
        $display("FAIL rd_count_pre_r: got %h expected %h", rd_count, model_rd);
      end
      if (model_rd != 32'hFFFF_FFFF) model_rd = model_rd + 32'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b0) begin
      failures++;
      $display("FAIL handshakes_in_reset: got %b expected 00000",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b11100)
    begin
      failures++;
      $display("FAIL after_reset_ready: got %b expected 11100",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
    end
    checks++;
    if (wr_count !== 32'd0 || rd_count !== 32'd0 || S_AXI_RDATA !== '0) begin
      failures++;
      $display("FAIL reset_values: got wr=%h rd=%h rdata=%h expected 0/0/0", wr_count, rd_count,
               S_AXI_RDATA);
    end
  endtask

  task automatic test_write_same_cycle();
    S_AXI_AWADDR  = 32'h0000_0010;
    S_AXI_WDATA   = $urandom;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_BREADY  = 1'b1;
    b_q.push_back(RESP);
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    checks++;
    if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b100) begin
      failures++;
      $display("FAIL same_cycle_bvalid: got bvalid/awready/wready=%b expected 100",
               {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY});
    end
    tick();
    checks++;
    if (S_AXI_BVALID !== 1'b0 || wr_count !== 32'd1 || S_AXI_AWREADY !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle_done: got bvalid=%b wr=%h awready=%b expected 0/1/1",
               S_AXI_BVALID, wr_count, S_AXI_AWREADY);
    end
  endtask

  task automatic test_aw_then_w();
    S_AXI_AWVALID = 1'b1;
    S_AXI_BREADY  = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID} !== 3'b010) begin
        failures++;
        $display("FAIL aw_held_cycle%0d: got awready/wready/bvalid=%b expected 010", c,
                 {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID});
      end
      if (c == 5) begin
        S_AXI_WVALID = 1'b1;
        b_q.push_back(RESP);
      end
      tick();
    end
    S_AXI_WVALID = 1'b0;
    checks++;
    if (S_AXI_BVALID !== 1'b1 || S_AXI_AWREADY !== 1'b0) begin
      failures++;
      $display("FAIL aw_then_w_bvalid: got bvalid=%b awready=%b expected 1/0", S_AXI_BVALID,
               S_AXI_AWREADY);
    end
    tick();
    checks++;
    if (S_AXI_BVALID !== 1'b0 || wr_count !== 32'd2) begin
      failures++;
      $display("FAIL aw_then_w_count: got bvalid=%b wr=%h expected 0/2", S_AXI_BVALID, wr_count);
    end
  endtask

  task automatic test_read_stall();
    S_AXI_ARADDR  = 32'h0000_1234;
    S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY  = 1'b0;
    r_q.push_back(32'h0000_1234);
    tick();
    S_AXI_ARVALID = 1'b0;
    S_AXI_ARADDR  = 32'hFFFF_0000;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h0000_1234 || S_AXI_RRESP !== RESP ||
          S_AXI_ARREADY !== 1'b0 || rd_count !== 32'd0) begin
        failures++;
        $display("FAIL read_stall_%0d: got rvalid=%b rdata=%h rresp=%b arready=%b rd=%h", i,
                 S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_ARREADY, rd_count);
      end
      if (i == 9) S_AXI_RREADY = 1'b1;
      tick();
    end
    S_AXI_RREADY = 1'b0;
    checks++;
    if (S_AXI_RVALID !== 1'b0 || rd_count !== 32'd1 || S_AXI_ARREADY !== 1'b1) begin
      failures++;
      $display("FAIL read_done: got rvalid=%b rd=%h arready=%b expected 0/1/1", S_AXI_RVALID,
               rd_count, S_AXI_ARREADY);
    end
  endtask

  task automatic test_concurrent();
    logic [31:0] pre_wr, pre_rd;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARVALID = 1'b1;
    S_AXI_ARADDR  = 32'h0000_0ABC;
    S_AXI_BREADY  = 1'b0;
    S_AXI_RREADY  = 1'b0;
    b_q.push_back(RESP);
    r_q.push_back(32'h0000_0ABC);
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    checks++;
    if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b11) begin
      failures++;
      $display("FAIL concurrent_valid: got bvalid/rvalid=%b expected 11",
               {S_AXI_BVALID, S_AXI_RVALID});
    end
    pre_wr = model_wr;
    pre_rd = model_rd;
    S_AXI_BREADY = 1'b1;
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    S_AXI_RREADY = 1'b0;
    checks++;
    if (wr_count !== pre_wr + 32'd1 || rd_count !== pre_rd + 32'd1) begin
      failures++;
      $display("FAIL concurrent_counts: got wr=%h rd=%h expected %h/%h", wr_count, rd_count,
               pre_wr + 32'd1, pre_rd + 32'd1);
    end
  endtask

  // n writes and n reads issued back to back over 2n cycles.
  task automatic run_streams(input int n, input logic [31:0] addr);
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_BREADY  = 1'b1;
    S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY  = 1'b1;
    S_AXI_ARADDR  = addr;
    for (int i = 0; i < n; i++) begin
      b_q.push_back(RESP);
      r_q.push_back(addr);
    end
    repeat (2 * n) tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pre_wr, pre_rd;
    pre_wr = model_wr;
    pre_rd = model_rd;
    run_streams(4, 32'hA5A5_0004);
    checks++;
    if (wr_count !== pre_wr + 32'd4 || rd_count !== pre_rd + 32'd4) begin
      failures++;
      $display("FAIL throughput: got wr=%h rd=%h expected %h/%h", wr_count, rd_count,
               pre_wr + 32'd4, pre_rd + 32'd4);
    end
  endtask

  task automatic test_saturation();
    force dut.wr_count_d = 32'hFFFF_FFFE;
    force dut.rd_count_d = 32'hFFFF_FFFE;
    tick();
    release dut.wr_count_d;
    release dut.rd_count_d;
    model_wr = 32'hFFFF_FFFE;
    model_rd = 32'hFFFF_FFFE;
    checks++;
    if (wr_count !== 32'hFFFF_FFFE || rd_count !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL preload: got wr=%h rd=%h expected fffffffe", wr_count, rd_count);
    end
    run_streams(2, 32'h0000_5A5A);
    checks++;
    if (wr_count !== 32'hFFFF_FFFF || rd_count !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL saturate: got wr=%h rd=%h expected ffffffff", wr_count, rd_count);
    end
  endtask

  task automatic test_reset_mid();
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARVALID = 1'b1;
    S_AXI_ARADDR  = 32'h0000_0777;
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    checks++;
    if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b11) begin
      failures++;
      $display("FAIL pending_before_reset: got %b expected 11", {S_AXI_BVALID, S_AXI_RVALID});
    end
    reset        = 1'b1;
    S_AXI_BREADY = 1'b1;
    S_AXI_RREADY = 1'b1;
    #1;
    checks++;
    if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_ARREADY} !== 4'b0) begin
      failures++;
      $display("FAIL valid_during_reset: got %b expected 0000",
               {S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_ARREADY});
    end
    tick();
    checks++;
    if (S_AXI_BVALID !== 1'b0 || wr_count !== 32'd0 || rd_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_clear: got bvalid=%b wr=%h rd=%h expected 0/0/0", S_AXI_BVALID,
               wr_count, rd_count);
    end
    b_q.delete();
    r_q.delete();
    model_wr     = '0;
    model_rd     = '0;
    reset        = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_RREADY = 1'b0;
    tick();
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b11100 ||
        wr_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_release: got %b wr=%h expected 11100/0",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID},
               wr_count);
    end
    run_streams(1, 32'h0000_0042);
    checks++;
    if (wr_count !== 32'd1 || rd_count !== 32'd1) begin
      failures++;
      $display("FAIL after_reset_txn: got wr=%h rd=%h expected 1/1", wr_count, rd_count);
    end
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_aw_then_w();
    test_read_stall();
    test_concurrent();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    tick();
    checks++;
    if (b_q.size() != 0 || r_q.size() != 0) begin
      failures++;
      $display("FAIL missing_responses: got %0d B and %0d R outstanding expected 0/0",
               b_q.size(), r_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
